// File: rtl/det_event_logger.sv
// Timestamps each detection from the 10110 sequence detector and queues it in a
// small show-ahead FIFO read over valid/ready; also counts detections and flags drops.
module det_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  output logic             ev_valid,
  output logic [TS_W-1:0]  ev_ts,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] det_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]  mem [DEPTH];
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic [TS_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic pop, push, drop, full;

  always_comb begin
    pop      = valid_q && ev_ready;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push     = det_in && (!full || pop);
    drop     = det_in && full && !pop;

    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    valid_d  = (wr_ptr_d != rd_ptr_d);

    // The next head is either an entry already in memory or, when the FIFO drains
    // to just this push, the timestamp being written this very cycle.
    head_d = '0;
    if (valid_d) begin
      if (push && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
        head_d = ts_q;
      end else begin
        head_d = mem[rd_ptr_d[AW-1:0]];
      end
    end

    if (clr_ovf) begin
      cnt_d = CNT_W'(det_in);
    end else if (det_in && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // A drop in the same cycle as a clear wins.
    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define what is valid and
  // head_q is forced to zero when empty, so stale contents never reach ev_ts.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= ts_q;
    end
  end

  assign ev_valid  = valid_q;
  assign ev_ts     = head_q;
  assign det_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_det_event_logger.sv
// Randomized plus directed bench for det_event_logger: a queue-based reference
// model feeds a scoreboard that a separate monitor checks every cycle.
module tb_det_event_logger;

  localparam int TS_W  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             det_in = 1'b0;
  logic             ev_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             ev_valid;
  logic [TS_W-1:0]  ev_ts;
  logic [CNT_W-1:0] det_count;
  logic             overflow;

  det_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .det_in    (det_in),
    .ev_valid  (ev_valid),
    .ev_ts     (ev_ts),
    .ev_ready  (ev_ready),
    .det_count (det_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: expected FIFO contents, timestamp, count and overflow flag.
  int exp_q[$];
  int ts_m  = 0;
  int cnt_m = 0;
  bit ovf_m = 1'b0;
  bit mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs at the falling edge, then advance the model
  // to the state the DUT will hold after the next rising edge.
  task automatic step(input bit d, input bit r, input bit c, input bit rs);
    int occ;
    bit pop, full, push, drop;
    @(negedge clk);
    det_in   = d;
    ev_ready = r;
    clr_ovf  = c;
    rst      = rs;
    occ  = exp_q.size();
    pop  = (occ > 0) && r;
    full = (occ >= DEPTH);
    push = d && (!full || pop);
    drop = d && full && !pop;
    #2;
    if (!rs) begin
      exp_q.delete();
      ts_m  = 0;
      cnt_m = 0;
      ovf_m = 1'b0;
    end else begin
      if (push) exp_q.push_back(ts_m);
      if (c) cnt_m = d ? 1 : 0;
      else if (d && cnt_m < CNT_MAX) cnt_m = cnt_m + 1;
      if (drop) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
      ts_m = (ts_m + 1) % TS_MOD;
    end
  endtask

  task automatic idle_until_ts(input int target);
    for (int i = 0; i < 2 * TS_MOD && ts_m != target; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reach_ts", ts_m, target);
  endtask

  // Monitor: compares presented outputs with the model just after the falling
  // edge and retires the expected head whenever a handshake is presented.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check("ev_valid", ev_valid, exp_q.size() != 0);
        check("ev_ts", ev_ts, (exp_q.size() != 0) ? exp_q[0] : 0);
        check("det_count", det_count, cnt_m);
        check("overflow", overflow, ovf_m);
        if (rst && ev_valid && ev_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    mon_en = 1'b1;

    // Single event at ts=5.
    idle_until_ts(5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Fill and overflow: pulses at ts=2,4,6,8,10, then drain.
    idle_until_ts(2);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (i < 4) step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Full FIFO with simultaneous pop and push.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Timestamp wrap: pulses at ts=15 and 0.
    idle_until_ts(TS_MOD - 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Saturation and clear.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset mid-operation with 3 entries stored and overflow set.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic including occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) != 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/det_event_logger.md
# det_event_logger

Downstream consumer of the overlapping 10110 sequence detector. It takes the detector's per-bit detect output (`det_in`), tags each detection with a free-running bit-time timestamp, and buffers the timestamps in a small show-ahead FIFO. A host reads the FIFO over a valid/ready handshake. A saturating detection counter and a sticky overflow flag report totals and dropped events.

## Interface
Parameters:
- `TS_W`, default 16: timestamp width; the bit-time counter wraps modulo 2^TS_W.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `CNT_W`, default 8: width of the saturating detection counter.

Ports:
- `clk`  in  1  clock. Reset `rst` is synchronous, active-low; clock is `clk`.
- `rst`  in  1  synchronous active-low reset.
- `det_in`  in  1  detector output; one detection per cycle in which it is sampled high.
- `ev_valid`  out  1  FIFO non-empty; head entry is presented.
- `ev_ts`  out  TS_W  timestamp of the head entry; 0 whenever `ev_valid`=0.
- `ev_ready`  in  1  host accepts the head entry.
- `det_count`  out  CNT_W  total detections since reset or clear; saturates at all-ones.
- `overflow`  out  1  sticky; set when a detection is dropped because the FIFO is full.
- `clr_ovf`  in  1  clears `overflow` and `det_count`.

## Operation
- Reset state (rst=0 at a clk edge): ts=0, FIFO empty, `ev_valid`=0, `ev_ts`=0, `det_count`=0, `overflow`=0.
- Timestamp counter `ts`:
  - Increments every clk cycle while rst=1.
  - Wraps from 2^TS_W−1 to 0.
  - The cycle immediately following a reset edge has ts=0.
- `det_in` is sampled on every rising clk edge. The detector output is combinational (Mealy), so it must not be registered again before sampling.
- Push: when `det_in`=1, write the current ts value (the ts of that cycle) into the FIFO.
  - Push is allowed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Drop: when `det_in`=1, the FIFO is full, and no pop occurs, the event is discarded and `overflow` is set at that edge.
- Pop: occurs when `ev_valid`=1 and `ev_ready`=1. The head entry is removed and the next entry is presented on the following cycle.
- Simultaneous push and pop at any occupancy: occupancy is unchanged and order is preserved.
- Push into an empty FIFO: no bypass. The entry becomes visible the next cycle.
- `det_count`:
  - Increments on every cycle with `det_in`=1, including dropped events.
  - Holds at 2^CNT_W−1 once reached.
- `clr_ovf`=1 at an edge:
  - `det_count` becomes 0, or 1 if `det_in`=1 in that same cycle.
  - `overflow` becomes 0, or 1 if a drop occurs in that same cycle (set beats clear).
  - FIFO contents and ts are unaffected.
- Pointers: read/write pointers are log2(DEPTH)+1 bits wide, and the extra MSB distinguishes full from empty. Occupancy never exceeds DEPTH.
- `ev_ts` must be muxed to 0 when the FIFO is empty. Stale memory contents must never appear on it.

## Timing
- Latency: `det_in`=1 in cycle n with ts=T and an empty FIFO → `ev_valid`=1 and `ev_ts`=T in cycle n+1.
- `det_count` and `overflow` update at the same edge that samples `det_in`, so they are visible in cycle n+1.
- Handshake:
  - `ev_valid` and `ev_ts` are registered outputs. Neither depends combinationally on `ev_ready`.
  - Once `ev_valid` is asserted, it and `ev_ts` stay stable until the pop occurs.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all stored entries are discarded. All outputs take their reset values in the cycle after the reset edge, regardless of `det_in`, `ev_ready` and `clr_ovf`.

## Test plan
- **Single event:** release reset, pulse `det_in` in the cycle with ts=5, `ev_ready`=0 → from the next cycle `ev_valid`=1, `ev_ts`=5, `det_count`=1, `overflow`=0.
- **Fill and overflow (DEPTH=4):**
  - Hold `ev_ready`=0 and pulse `det_in` at ts=2,4,6,8,10.
  - After ts=10: `det_count`=5, `overflow`=1.
  - Then assert `ev_ready`=1 → `ev_ts` = 2,4,6,8 on consecutive cycles, then `ev_valid`=0 and `ev_ts`=0.
- **Full with simultaneous pop and push:** with the FIFO full and `ev_ready`=1, pulse `det_in` at ts=20 → push accepted, occupancy stays 4, `overflow` stays 0. The entry with ts=20 pops last.
- **Wrap-around (TS_W=4):** pulse `det_in` at ts=15 and again on the next cycle → entries read out as 15 then 0.
- **Saturation and clear (CNT_W=3):**
  - Nine pulses → `det_count`=7.
  - `clr_ovf`=1 together with `det_in`=1 → `det_count`=1.
  - `clr_ovf`=1 alone on a later cycle → `det_count`=0, `overflow`=0.
- **Reset mid-operation:** with 3 entries stored and `overflow`=1, drive rst=0 for one cycle with `det_in`=1 → next cycle `ev_valid`=0, `ev_ts`=0, `det_count`=0, `overflow`=0, ts=0.
